// File: rtl/tff_counter_pkg.sv
// ----------------------------------------------------------------------------
// tff_counter_pkg
//
// Purpose : Shared definitions for the T flip-flop based counter family.
//           Holds the mode encoding and the helper that decides where a
//           counter lands when it runs into one of its limits.
//
// Contents:
//   mode_e        - operating mode encoding (TOGGLE / UP / DOWN / LOAD)
//   MODE_WIDTH    - width of the mode field on the counter port list
//   limitTarget() - value reached when counting past a limit, for either
//                   saturating or modulo behaviour
// ----------------------------------------------------------------------------
package tff_counter_pkg;

    localparam int MODE_WIDTH = 2;

    typedef enum logic [MODE_WIDTH-1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_UP     = 2'd1,
        MODE_DOWN   = 2'd2,
        MODE_LOAD   = 2'd3
    } mode_e;

    // Value the counter moves to when it is already sitting on the limit
    // in its counting direction. Saturating counters stay on the limit;
    // modulo counters jump to the opposite end of the 0..maxVal range.
    function automatic int unsigned limitTarget(
        input int unsigned maxVal,
        input bit          saturate,
        input bit          countUp
    );
        int unsigned result;
        if (countUp) begin
            result = saturate ? maxVal : 0;
        end else begin
            result = saturate ? 0 : maxVal;
        end
        return result;
    endfunction

endpackage : tff_counter_pkg

// File: rtl/tff_counter_cell.sv
// ----------------------------------------------------------------------------
// tff_cell
//
// Purpose : Single-bit T flip-flop. The stored bit inverts on a rising clock
//           edge whenever the toggle input is high and holds otherwise.
//
// Ports:
//   clk   - clock, state changes on the rising edge
//   reset - asynchronous active-low reset, clears the bit to 0
//   t_i   - toggle enable
//   q_o   - stored bit
// ----------------------------------------------------------------------------
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t_i,
    output logic q_o
);

    logic bit_q;

    // The cell can only flip or hold; there is deliberately no data input,
    // so every change of state is expressed as a toggle by the parent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_q <= 1'b0;
        end else if (t_i) begin
            bit_q <= ~bit_q;
        end
    end

    assign q_o = bit_q;

endmodule : tff_cell

// File: rtl/tff_counter.sv
// ----------------------------------------------------------------------------
// tff_counter
//
// Purpose : Parametrised counter / toggle register built from WIDTH T
//           flip-flop cells. The desired next value is computed from the
//           current state and the selected mode, then converted into per-bit
//           toggle enables (q ^ next) that drive the cells.
//
// Parameters:
//   WIDTH    - counter width in bits (>= 1)
//   MAX      - highest legal count value (1 .. 2**WIDTH-1)
//   SATURATE - 0: wrap modulo MAX+1, 1: stop at 0 / MAX
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset (q = 0, wrap = 0)
//   en       - advance when high, hold when low
//   clear    - synchronous clear to 0, overrides en and mode
//   mode     - 0 TOGGLE, 1 UP, 2 DOWN, 3 LOAD
//   t_vec    - per-bit toggle mask for TOGGLE mode
//   load_val - value taken in LOAD mode (clamped to MAX)
//   q        - counter state
//   wrap     - registered one-cycle pulse after a modulo wrap
//   at_limit - combinational: q==MAX in UP, q==0 in DOWN, else 0
// ----------------------------------------------------------------------------
module tff_counter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = (2 ** WIDTH) - 1,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clear,
    input  logic [MODE_WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]      t_vec,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      q,
    output logic                  wrap,
    output logic                  at_limit
);

    localparam logic [WIDTH-1:0] MaxVal    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] UpTarget  = WIDTH'(limitTarget(MAX, SATURATE != 0, 1'b1));
    localparam logic [WIDTH-1:0] DnTarget  = WIDTH'(limitTarget(MAX, SATURATE != 0, 1'b0));
    localparam logic             WrapsAtLimit = (SATURATE == 0);

    mode_e            modeSel;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] toggleVal;
    logic [WIDTH-1:0] toggle;
    logic             wrap_q;
    logic             wrap_d;

    assign modeSel   = mode_e'(mode);
    assign toggleVal = state_q ^ t_vec;

    // Next-state selection. Priority is clear, then hold, then mode.
    // Clamping comparisons are zero-extended by one bit so they stay
    // meaningful even when MAX is the all-ones value of the width.
    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        if (clear) begin
            state_d = '0;
        end else if (en) begin
            case (modeSel)
                MODE_TOGGLE: begin
                    if ({1'b0, toggleVal} > {1'b0, MaxVal}) begin
                        state_d = MaxVal;
                    end else begin
                        state_d = toggleVal;
                    end
                end
                MODE_UP: begin
                    // Anything at or above MAX is treated as sitting on MAX.
                    if ({1'b0, state_q} >= {1'b0, MaxVal}) begin
                        state_d = UpTarget;
                        wrap_d  = WrapsAtLimit;
                    end else begin
                        state_d = state_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (state_q == '0) begin
                        state_d = DnTarget;
                        wrap_d  = WrapsAtLimit;
                    end else begin
                        state_d = state_q - WIDTH'(1);
                    end
                end
                MODE_LOAD: begin
                    if ({1'b0, load_val} > {1'b0, MaxVal}) begin
                        state_d = MaxVal;
                    end else begin
                        state_d = load_val;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Each cell flips exactly the bits that differ between the current
    // and the desired state, so the cells always land on state_d.
    assign toggle = state_q ^ state_d;

    for (genvar i = 0; i < WIDTH; i++) begin : gCell
        tff_cell uCell (
            .clk   (clk),
            .reset (reset),
            .t_i   (toggle[i]),
            .q_o   (state_q[i])
        );
    end

    // Wrap pulse is registered so it lines up with the wrapped q value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    // Limit indication depends on the mode currently applied, not on the
    // mode that produced the present state.
    always_comb begin
        at_limit = 1'b0;
        case (modeSel)
            MODE_UP:   at_limit = (state_q == MaxVal);
            MODE_DOWN: at_limit = (state_q == '0);
            default:   at_limit = 1'b0;
        endcase
    end

    assign q    = state_q;
    assign wrap = wrap_q;

endmodule : tff_counter
